// File: rtl/uart_tx_byte_queue.sv
// Elastic byte queue between UART RX strobes and the UART TX start/busy/done handshake.
// Optional drop counter output enabled by defining UART_QUEUE_STATS_EN.
`timescale 1ns/1ps
module uart_tx_byte_queue #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rx_datav_in,
  input  logic [DATA_W-1:0]     rx_byte_in,
  input  logic                  tx_active_in,
  input  logic                  tx_done_in,
  output logic                  tx_datav_op,
  output logic [DATA_W-1:0]     tx_byte_op,
  output logic [DEPTH_LOG2:0]   fifo_count_op,
  output logic                  fifo_empty_op,
  output logic                  fifo_full_op,
`ifdef UART_QUEUE_STATS_EN
  output logic [15:0]           drop_cnt_op,
`endif
  output logic                  overflow_op
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] CountOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [DATA_W-1:0]       tx_byte_q, tx_byte_d;
  logic                    tx_datav_q, tx_datav_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_W-1:0]       mem_q [Depth];

  logic empty, full, launch, push, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; tx_done_in only matters while a frame is outstanding
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty && !tx_active_in) state_d = StBusy;
      StBusy:  if (tx_done_in)              state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: launch pops the head into the TX holding register
  always_comb begin
    launch = 1'b0;
    unique case (state_q)
      StIdle:  launch = !empty && !tx_active_in;
      StBusy:  launch = 1'b0;
      default: launch = 1'b0;
    endcase
  end

  // A full queue still accepts a byte when the head leaves on the same edge
  assign push = rx_datav_in && (!full || launch);
  assign drop = rx_datav_in && full && !launch;

  always_comb begin
    wr_ptr_d   = push   ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = launch ? rd_ptr_q + PtrOne : rd_ptr_q;
    tx_byte_d  = launch ? mem_q[rd_ptr_q]   : tx_byte_q;
    tx_datav_d = launch;
    overflow_d = overflow_q | drop;
    count_d    = count_q;
    unique case ({push, launch})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_byte_q  <= '0;
      tx_datav_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_byte_q  <= tx_byte_d;
      tx_datav_q <= tx_datav_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_byte_in;
    end
  end

`ifdef UART_QUEUE_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_op = drop_cnt_q;
`endif

  assign tx_datav_op   = tx_datav_q;
  assign tx_byte_op    = tx_byte_q;
  assign fifo_count_op = count_q;
  assign fifo_empty_op = empty;
  assign fifo_full_op  = full;
  assign overflow_op   = overflow_q;

endmodule
